// File: rtl/trap_seq.sv
// Trap-entry / mret sequencer for the machine-mode CSR file. Owns the CSR
// file's single read and write port while a trap or mret sequence is running.
module trap_seq #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret_req,
  input  logic        core_wb_csr,
  input  logic [11:0] core_waddr,
  input  logic [31:0] core_wdata,
  input  logic [11:0] core_raddr,
  output logic [31:0] core_rdata,
  output logic        wb_csr,
  output logic [11:0] write_addr,
  output logic [31:0] in_data,
  output logic [11:0] addr,
  input  logic [31:0] out_data,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [3:0] {
    IDLE, T_EPC, T_CAUSE, T_TVAL, T_RD, T_VEC, T_WST, M_RD, M_EPC, M_WST, REDIR
  } state_t;

  state_t      state, state_nx;
  logic [31:0] cause_q, val_q, st_q, tv_q, redirect_pc_q;
  logic [29:0] pc_q, ep_q;
  logic [31:0] trap_st, mret_st, tv_base, trap_target;

  assign core_rdata  = out_data;
  assign redirect_pc = redirect_pc_q;

  // mstatus images written back on trap entry and on mret.
  always_comb begin
    trap_st        = st_q;
    trap_st[7]     = st_q[3];
    trap_st[3]     = 1'b0;
    trap_st[12:11] = 2'b11;
    mret_st        = st_q;
    mret_st[3]     = st_q[7];
    mret_st[7]     = 1'b1;
  end

  always_comb begin
    tv_base     = {tv_q[31:2], 2'b00};
    trap_target = tv_base;
    if (VECTORED_EN && (tv_q[1:0] == 2'b01) && cause_q[31])
      trap_target = tv_base + {cause_q[29:0], 2'b00};
  end

  always_comb begin
    state_nx       = state;
    addr           = CSR_MSTATUS;
    wb_csr         = 1'b0;
    write_addr     = 12'h000;
    in_data        = 32'h0;
    busy           = 1'b1;
    redirect_valid = 1'b0;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        addr       = core_raddr;
        write_addr = core_waddr;
        in_data    = core_wdata;
        // A request claims the write port, so that cycle's core write is dropped.
        if (trap_req)      state_nx = T_EPC;
        else if (mret_req) state_nx = M_RD;
        else               wb_csr   = core_wb_csr;
      end
      T_EPC: begin
        wb_csr = 1'b1; write_addr = CSR_MEPC; in_data = {pc_q, 2'b00};
        state_nx = T_CAUSE;
      end
      T_CAUSE: begin
        wb_csr = 1'b1; write_addr = CSR_MCAUSE; in_data = cause_q;
        state_nx = T_TVAL;
      end
      T_TVAL: begin
        wb_csr = 1'b1; write_addr = CSR_MTVAL; in_data = val_q;
        state_nx = T_RD;
      end
      T_RD:  begin addr = CSR_MSTATUS; state_nx = T_VEC; end
      T_VEC: begin addr = CSR_MTVEC;   state_nx = T_WST; end
      T_WST: begin
        wb_csr = 1'b1; write_addr = CSR_MSTATUS; in_data = trap_st;
        state_nx = REDIR;
      end
      M_RD:  begin addr = CSR_MSTATUS; state_nx = M_EPC; end
      M_EPC: begin addr = CSR_MEPC;    state_nx = M_WST; end
      M_WST: begin
        wb_csr = 1'b1; write_addr = CSR_MSTATUS; in_data = mret_st;
        state_nx = REDIR;
      end
      REDIR: begin redirect_valid = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cause_q       <= 32'h0;
      pc_q          <= 30'h0;
      val_q         <= 32'h0;
      st_q          <= 32'h0;
      tv_q          <= 32'h0;
      ep_q          <= 30'h0;
      redirect_pc_q <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == IDLE && trap_req) begin
        cause_q <= trap_cause;
        pc_q    <= trap_pc[31:2];
        val_q   <= trap_val;
      end
      if (state == T_RD || state == M_RD) st_q <= out_data;
      if (state == T_VEC) tv_q <= out_data;
      if (state == M_EPC) ep_q <= out_data[31:2];
      // Target is registered on the way into REDIR and then held until the next one.
      if (state == T_WST) redirect_pc_q <= trap_target;
      if (state == M_WST) redirect_pc_q <= {ep_q, 2'b00};
    end
  end

endmodule
